tail_light_sequencer: RTL and testbench

Sequencer and arbiter for the six-lamp tail-light datapath (left lamps L1–L3, right lamps R1–R3). It accepts hazard, left-turn and right-turn requests and grants the lamp bank to exactly one of them. It steps the granted pattern at a prescaled rate and drives registered lamp outputs. It sits between the board-level switch/key conditioning and the LED outputs in the top-level design.

---
 rtl/tail_light_pkg.sv | 79 +++++++
 rtl/tick_prescaler.sv | 30 +++
 rtl/tail_light_sequencer.sv | 155 +++++++++++++++
 tb/tb_tail_light_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared state encoding, lamp patterns and decode helpers for the
// tail-light sequencer.
package tail_light_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    L1     = 4'd1,
    L2     = 4'd2,
    L3     = 4'd3,
    R1     = 4'd4,
    R2     = 4'd5,
    R3     = 4'd6,
    HAZ_ON = 4'd7,
    OFF    = 4'd8
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  typedef struct packed {
    logic [2:0] l;
    logic [2:0] r;
  } lamps_t;

  function automatic lamps_t lamp_decode(
    input state_t s
  );
    lamps_t d;
    d.l = LAMP_OFF;
    d.r = LAMP_OFF;
    unique case (s)
      L1:      d.l = LAMP_1;
      L2:      d.l = LAMP_2;
      L3:      d.l = LAMP_3;
      R1:      d.r = LAMP_1;
      R2:      d.r = LAMP_2;
      R3:      d.r = LAMP_3;
      HAZ_ON: begin
        d.l = LAMP_3;
        d.r = LAMP_3;
      end
      default: ;
    endcase
    return d;
  endfunction

  // Priority: hazard, then an unambiguous turn side.
  function automatic state_t arbitrate(
    input logic haz,
    input logic left,
    input logic right
  );
    state_t s;
    if (haz)
      s = HAZ_ON;
    else if (left && !right)
      s = L1;
    else if (right && !left)
      s = R1;
    else
      s = IDLE;
    return s;
  endfunction

  function automatic logic is_left(
    input state_t s
  );
    return (s == L1) || (s == L2) || (s == L3);
  endfunction

  function automatic logic is_right(
    input state_t s
  );
    return (s == R1) || (s == R2) || (s == R3);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: pulses tick on the last cycle of each
// TICK_DIV-cycle window, restarting whenever cleared or disabled.
module tick_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear || !enable || tick)
      count <= '0;
    else
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Six-lamp tail-light arbiter/sequencer with registered outputs.
// Optional brake overlay enabled by defining TAIL_SEQ_BRAKE_EN.
import tail_light_pkg::*;

module tail_light_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hazard_req,
  input  logic       left_req,
  input  logic       right_req,
`ifdef TAIL_SEQ_BRAKE_EN
  input  logic       brake_req,
`endif
  output logic [2:0] lamps_l,
  output logic [2:0] lamps_r,
  output logic [3:0] state_o,
  output logic       conflict
);

  state_t state;
  state_t next_state;
  state_t arb;
  logic   tick;
  logic   clear;
  logic   enable;
  logic   both;
  logic   conflict_next;
  lamps_t lamp_next;

  assign enable = (state != IDLE);
  assign clear  = (next_state != state);
  assign both   = left_req && right_req && !hazard_req;
  assign arb    = arbitrate(hazard_req, left_req, right_req);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .tick   (tick)
  );

  // Turn states yield to hazard immediately; OFF only at its tick.
  always_comb begin
    next_state    = state;
    conflict_next = 1'b0;
    unique case (state)
      IDLE: begin
        next_state    = arb;
        conflict_next = both;
      end
      L1: begin
        if (hazard_req)
          next_state = HAZ_ON;
        else if (tick)
          next_state = L2;
      end
      L2: begin
        if (hazard_req)
          next_state = HAZ_ON;
        else if (tick)
          next_state = L3;
      end
      L3: begin
        if (hazard_req)
          next_state = HAZ_ON;
        else if (tick)
          next_state = OFF;
      end
      R1: begin
        if (hazard_req)
          next_state = HAZ_ON;
        else if (tick)
          next_state = R2;
      end
      R2: begin
        if (hazard_req)
          next_state = HAZ_ON;
        else if (tick)
          next_state = R3;
      end
      R3: begin
        if (hazard_req)
          next_state = HAZ_ON;
        else if (tick)
          next_state = OFF;
      end
      HAZ_ON: begin
        if (tick)
          next_state = OFF;
      end
      OFF: begin
        if (tick) begin
          next_state    = arb;
          conflict_next = both;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef TAIL_SEQ_BRAKE_EN
  // Marks an OFF phase that belongs to a hazard flash cycle.
  logic haz_off;
  logic haz_off_next;

  assign haz_off_next = (next_state == OFF) &&
                        ((state == HAZ_ON) || haz_off);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      haz_off <= 1'b0;
    else
      haz_off <= haz_off_next;
  end

  always_comb begin
    lamp_next = lamp_decode(next_state);
    if (brake_req && (next_state != HAZ_ON) &&
        !haz_off_next) begin
      if (!is_left(next_state))
        lamp_next.l = LAMP_3;
      if (!is_right(next_state))
        lamp_next.r = LAMP_3;
    end
  end
`else
  always_comb begin
    lamp_next = lamp_decode(next_state);
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lamps_l  <= LAMP_OFF;
      lamps_r  <= LAMP_OFF;
      conflict <= 1'b0;
    end else begin
      state    <= next_state;
      lamps_l  <= lamp_next.l;
      lamps_r  <= lamp_next.r;
      conflict <= conflict_next;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Scoreboard bench for tail_light_sequencer at TICK_DIV = 4.
// Covers brake overlay when TAIL_SEQ_BRAKE_EN is defined.
import tail_light_pkg::*;

module tb_tail_light_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hazard_req = 1'b0;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
`ifdef TAIL_SEQ_BRAKE_EN
  logic       brake_req = 1'b0;
`endif
  logic [2:0] lamps_l;
  logic [2:0] lamps_r;
  logic [3:0] state_o;
  logic       conflict;

  typedef struct {
    int         cyc;
    logic [3:0] st;
    logic [2:0] l;
    logic [2:0] r;
    logic       cf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  tail_light_sequencer #(
    .TICK_DIV (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .hazard_req (hazard_req),
    .left_req   (left_req),
    .right_req  (right_req),
`ifdef TAIL_SEQ_BRAKE_EN
    .brake_req  (brake_req),
`endif
    .lamps_l    (lamps_l),
    .lamps_r    (lamps_r),
    .state_o    (state_o),
    .conflict   (conflict)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare each queued expectation on its own cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc ||
          state_o  !== mon_e.st ||
          lamps_l  !== mon_e.l ||
          lamps_r  !== mon_e.r ||
          conflict !== mon_e.cf) begin
        n_fail++;
        $display("FAIL cyc%0d: got st=%0d l=%b r=%b cf=%b want st=%0d l=%b r=%b cf=%b (due %0d)",
                 cyc, state_o, lamps_l, lamps_r, conflict,
                 mon_e.st, mon_e.l, mon_e.r, mon_e.cf,
                 mon_e.cyc);
      end
    end
  end

  // Drive inputs now; expect n cycles of the given outputs.
  task automatic seg(
    input logic       h,
    input logic       lf,
    input logic       rt,
    input int         n,
    input state_t     st,
    input logic [2:0] ll,
    input logic [2:0] rr,
    input logic       cf
  );
    exp_t e;
    hazard_req = h;
    left_req   = lf;
    right_req  = rt;
    for (int i = 0; i < n; i++) begin
      e.cyc = cyc + 1 + i;
      e.st  = st;
      e.l   = ll;
      e.r   = rr;
      e.cf  = cf;
      sb.push_back(e);
    end
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    seg(0, 0, 0, 1, IDLE, 3'b000, 3'b000, 0);

    // Left sequence held, wraps back to L1.
    seg(0, 1, 0, 4, L1,  3'b001, 3'b000, 0);
    seg(0, 1, 0, 4, L2,  3'b011, 3'b000, 0);
    seg(0, 1, 0, 4, L3,  3'b111, 3'b000, 0);
    seg(0, 1, 0, 4, OFF, 3'b000, 3'b000, 0);
    seg(0, 1, 0, 4, L1,  3'b001, 3'b000, 0);
    seg(0, 1, 0, 2, L2,  3'b011, 3'b000, 0);

    // Hazard preempts L2; OFF waits its tick.
    seg(1, 1, 0, 4, HAZ_ON, 3'b111, 3'b111, 0);
    seg(1, 1, 0, 4, OFF,    3'b000, 3'b000, 0);
    seg(1, 1, 0, 4, HAZ_ON, 3'b111, 3'b111, 0);
    seg(0, 0, 0, 4, OFF,    3'b000, 3'b000, 0);
    seg(0, 0, 0, 2, IDLE,   3'b000, 3'b000, 0);

    // Conflict pulses every IDLE arbitration.
    seg(0, 1, 1, 3, IDLE, 3'b000, 3'b000, 1);
    seg(0, 0, 0, 1, IDLE, 3'b000, 3'b000, 0);

    // Hazard from IDLE.
    seg(1, 0, 0, 4, HAZ_ON, 3'b111, 3'b111, 0);
    seg(1, 0, 0, 4, OFF,    3'b000, 3'b000, 0);
    seg(1, 0, 0, 4, HAZ_ON, 3'b111, 3'b111, 0);
    seg(0, 0, 0, 4, OFF,    3'b000, 3'b000, 0);
    seg(0, 0, 0, 1, IDLE,   3'b000, 3'b000, 0);

    // Right drops in R3, sequence still completes.
    seg(0, 0, 1, 4, R1,   3'b000, 3'b001, 0);
    seg(0, 0, 1, 4, R2,   3'b000, 3'b011, 0);
    seg(0, 0, 1, 2, R3,   3'b000, 3'b111, 0);
    seg(0, 0, 0, 2, R3,   3'b000, 3'b111, 0);
    seg(0, 0, 0, 4, OFF,  3'b000, 3'b000, 0);
    seg(0, 0, 0, 2, IDLE, 3'b000, 3'b000, 0);

    // Async reset in the middle of L2.
    seg(0, 1, 0, 4, L1, 3'b001, 3'b000, 0);
    seg(0, 1, 0, 2, L2, 3'b011, 3'b000, 0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (state_o !== 4'd0 || lamps_l !== 3'b000 ||
        lamps_r !== 3'b000 || conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d l=%b r=%b cf=%b want st=0 l=000 r=000 cf=0",
               state_o, lamps_l, lamps_r, conflict);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    seg(0, 0, 0, 2, IDLE, 3'b000, 3'b000, 0);

`ifdef TAIL_SEQ_BRAKE_EN
    brake_req = 1'b1;
    seg(0, 0, 0, 1, IDLE, 3'b111, 3'b111, 0);
    seg(0, 1, 0, 4, L1,   3'b001, 3'b111, 0);
    seg(0, 1, 0, 2, L2,   3'b011, 3'b111, 0);
    brake_req = 1'b0;
    seg(0, 0, 0, 2, L2,   3'b011, 3'b000, 0);
    seg(0, 0, 0, 4, L3,   3'b111, 3'b000, 0);
    seg(0, 0, 0, 4, OFF,  3'b000, 3'b000, 0);
    seg(0, 0, 0, 1, IDLE, 3'b000, 3'b000, 0);
`endif

    @(negedge clock);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
